car_queue: RTL and testbench
============================

CAR_QUEUE -- requirements
Module: car_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queued paid cars (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 1000, SHALL set the maximum clk cycles a wash may run before a fault.
REQ-003 Ports SHALL be, clock and reset first:
 clk  in  1  system clock, rising edge;
 reset  in  1  one clock; reset is asynchronous and active-low;
 enq_valid  in  1  POS presents an approved car;
 enq_sel  in  2  selection of that car (1 basic, 2 basic plus, 3 detail);
 enq_ready  out  1  queue can accept;
 wash_done  in  1  carwash completion level (stays high until carwash reset);
 sel_out  out  2  selection driven to carwash;
 approve_out  out  1  payment-approved level to carwash;
 wash_rst  out  1  active-high reset pulse to carwash;
 count  out  $clog2(DEPTH)+1  cars waiting;
 full, empty  out  1  queue flags;
 drop  out  1  one-cycle pulse, rejected entry;
 fault  out  1  sticky wash-timeout flag;
 washes  out  8  completed-wash counter.

Function
REQ-004 Enqueue SHALL occur on a rising clk edge when enq_valid && enq_ready && enq_sel != 0.
REQ-005 enq_valid with enq_sel == 0, or with enq_ready low, SHALL leave the queue unchanged and pulse drop for one cycle.
REQ-006 enq_ready SHALL equal !full, from registered count; simultaneous enqueue and dequeue while full SHALL reject the enqueue.
REQ-007 Read and write pointers SHALL wrap modulo DEPTH; full = (count == DEPTH), empty = (count == 0).
REQ-008 Simultaneous enqueue and dequeue when not full and not empty SHALL leave count unchanged.
REQ-009 FSM states SHALL be IDLE, LOAD, WASHING, CLEAR.
REQ-010 IDLE -> LOAD when !empty; no bypass, so an entry written into an empty queue is dequeued no earlier than the next cycle.
REQ-011 LOAD SHALL dequeue the head, register it into sel_out, set approve_out = 1, and go to WASHING next cycle.
REQ-012 WASHING SHALL hold sel_out and approve_out stable and count cycles in a watchdog counter.
REQ-013 WASHING -> CLEAR on a rising edge of wash_done (registered previous sample 0, current 1); washes increments, saturating at 255.
REQ-014 If the watchdog reaches TIMEOUT before a wash_done rising edge, fault SHALL set (sticky), washes SHALL not increment, and the FSM SHALL go to CLEAR.
REQ-015 A wash_done edge and timeout in the same cycle SHALL be treated as completion; fault SHALL stay clear.
REQ-016 CLEAR SHALL assert wash_rst for exactly one cycle, drive sel_out = 0 and approve_out = 0, clear the watchdog, and return to IDLE.
REQ-017 Minimum spacing between consecutive LOAD states SHALL be 3 cycles after the completion edge.
REQ-018 Enqueue SHALL continue in every FSM state.

Reset
REQ-019 While reset = 0, all state SHALL clear asynchronously: FSM = IDLE, pointers 0, count 0, empty 1, full 0, enq_ready 1, sel_out 0, approve_out 0, drop 0, fault 0, washes 0, watchdog 0, wash_done edge register 0.
REQ-020 wash_rst SHALL be 1 during reset so the carwash is held in its entry state.
REQ-021 Reset asserted mid-wash SHALL discard the queue and the in-flight car; no partial state survives.
REQ-022 Deassertion SHALL be synchronised by the integrator; the block assumes a clean release edge.

Structure
REQ-023 Shared package SHALL hold the selection codes (NO_SEL = 0, BASIC = 1, BASIC_PLUS = 2, DETAIL = 3) and the FSM state enumeration.
REQ-024 The storage/pointer logic SHALL be one sub-module, car_fifo (parameter DEPTH, width 2); car_queue holds the FSM, watchdog and counters.

Verification
REQ-025 Reset, push sel 3 once -> count 1 next cycle, LOAD the cycle after, sel_out = 3, approve_out = 1, count 0.
REQ-026 Push 1, 2, 3, 1, then 2 with no washes -> full = 1 after the 4th push, the 5th push drops with a 1-cycle drop pulse, count stays 4.
REQ-027 Push sel 0 -> drop pulse, count 0, FSM stays IDLE.
REQ-028 Wash in progress, raise wash_done -> one cycle wash_rst, sel_out 0, washes +1, next queued car loaded 3 cycles after the edge.
REQ-029 TIMEOUT = 10, wash_done held 0 -> fault = 1 after 10 WASHING cycles, wash_rst pulse, washes unchanged; fault stays 1 through later washes.
REQ-030 Reset pulsed low during WASHING with 2 queued -> all outputs at reset values immediately, count 0, wash_rst 1.

Source files
------------

// File: rtl/car_queue_pkg.sv
// car_queue_pkg: selection codes and wash-controller states shared by the car queue.
package car_queue_pkg;
    typedef enum logic [1:0] {
        NO_SEL     = 2'd0,
        BASIC      = 2'd1,
        BASIC_PLUS = 2'd2,
        DETAIL     = 2'd3
    } sel_e;
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WASHING,
        CLEAR
    } state_e;
endpackage

// File: rtl/car_fifo.sv
// car_fifo: circular buffer of paid car selections with occupancy count and flags.
module car_fifo
    import car_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
endmodule

// File: rtl/car_queue.sv
// car_queue: queues paid car selections and sequences them through the carwash
// with a completion-edge detector, a timeout watchdog and a completed-wash counter.
module car_queue
    import car_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_valid,
    input  logic [1:0]             enq_sel,
    output logic                   enq_ready,
    input  logic                   wash_done,
    output logic [1:0]             sel_out,
    output logic                   approve_out,
    output logic                   wash_rst,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   drop,
    output logic                   fault,
    output logic [7:0]             washes
);
    localparam int WW = $clog2(TIMEOUT + 1);
    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d, head;
    logic          approve_q, approve_d, drop_q, drop_d, fault_q, fault_d;
    logic          done_prev_q, enq_ok, deq, rise, expired;
    logic [7:0]    washes_q, washes_d;
    logic [WW-1:0] wd_q, wd_d;

    assign enq_ready = !full;
    assign enq_ok    = enq_valid && enq_ready && enq_sel != NO_SEL;
    assign deq       = state_q == LOAD;
    assign rise      = wash_done && !done_prev_q;
    assign expired   = wd_q == WW'(TIMEOUT - 1);

    car_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
        .clk(clk), .reset(reset), .wr_en(enq_ok), .wr_data(enq_sel), .rd_en(deq),
        .rd_data(head), .count(count), .full(full), .empty(empty)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        approve_d = approve_q;
        fault_d   = fault_q;
        washes_d  = washes_q;
        wd_d      = '0;
        drop_d    = enq_valid && !enq_ok;
        case (state_q)
            IDLE: state_d = empty ? IDLE : LOAD;
            LOAD: begin
                sel_d     = head;
                approve_d = 1'b1;
                state_d   = WASHING;
            end
            WASHING: begin
                wd_d = wd_q + 1'b1;
                // A completion edge wins over a watchdog expiry in the same cycle.
                if (rise || expired) begin
                    state_d   = CLEAR;
                    sel_d     = NO_SEL;
                    approve_d = 1'b0;
                    washes_d  = rise ? washes_q + 8'(washes_q != 8'hFF) : washes_q;
                    fault_d   = fault_q || !rise;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= NO_SEL;
            approve_q   <= 1'b0;
            drop_q      <= 1'b0;
            fault_q     <= 1'b0;
            washes_q    <= '0;
            wd_q        <= '0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            approve_q   <= approve_d;
            drop_q      <= drop_d;
            fault_q     <= fault_d;
            washes_q    <= washes_d;
            wd_q        <= wd_d;
            done_prev_q <= wash_done;
        end
    end

    // The carwash is held in reset for as long as this block is.
    assign wash_rst    = !reset || state_q == CLEAR;
    assign sel_out     = sel_q;
    assign approve_out = approve_q;
    assign drop        = drop_q;
    assign fault       = fault_q;
    assign washes      = washes_q;
endmodule

// File: tb/tb_car_queue.sv
// tb_car_queue: directed car-queue scenarios checked every cycle against a queue-based
// model of the car flow, plus hand-computed expectations at key points.
module tb_car_queue;
    localparam int DEPTH = 4, TIMEOUT = 10;
    logic       clk = 0, reset = 0, enq_valid = 0, wash_done = 0;
    logic [1:0] enq_sel = 0;
    logic       enq_ready, approve_out, wash_rst, full, empty, drop, fault;
    logic [1:0] sel_out;
    logic [2:0] count;
    logic [7:0] washes;
    int checks = 0, passed = 0;

    car_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_sel(enq_sel),
        .enq_ready(enq_ready), .wash_done(wash_done), .sel_out(sel_out),
        .approve_out(approve_out), .wash_rst(wash_rst), .count(count), .full(full),
        .empty(empty), .drop(drop), .fault(fault), .washes(washes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: cars waiting in q; m_bay is the car in the wash bay (0 = bay empty);
    // m_taking marks the cycle a car is being pulled from the queue; m_rst the reset cycle.
    int q[$];
    int m_bay = 0, m_age = 0, m_washes = 0;
    bit m_taking = 0, m_rst = 0, m_fault = 0, m_prev = 0, m_drop = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_bay = 0; m_age = 0; m_washes = 0;
            m_taking = 0; m_rst = 0; m_fault = 0; m_prev = 0; m_drop = 0;
        end else begin : step
            bit rise, take_n, rst_n;
            rise   = wash_done && !m_prev;
            take_n = 0;
            rst_n  = 0;
            m_drop = enq_valid && (enq_sel == 0 || q.size() == DEPTH);
            if (m_taking) begin
                m_bay = q.pop_front();
                m_age = 0;
            end else if (m_rst) begin
                m_bay = 0;
            end else if (m_bay != 0) begin
                if (rise || m_age + 1 == TIMEOUT) begin
                    if (rise) m_washes = (m_washes < 255) ? m_washes + 1 : 255;
                    else m_fault = 1;
                    m_bay = 0;
                    rst_n = 1;
                end else m_age++;
            end else take_n = q.size() != 0;
            if (enq_valid && !m_drop) q.push_back(int'(enq_sel));
            m_taking = take_n;
            m_rst    = rst_n;
            m_prev   = wash_done;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("m_count", count, q.size());
            chk("m_full", full, q.size() == DEPTH);
            chk("m_empty", empty, q.size() == 0);
            chk("m_enq_ready", enq_ready, q.size() != DEPTH);
            chk("m_sel_out", sel_out, m_bay);
            chk("m_approve", approve_out, m_bay != 0);
            chk("m_wash_rst", wash_rst, m_rst);
            chk("m_drop", drop, m_drop);
            chk("m_fault", fault, m_fault);
            chk("m_washes", washes, m_washes);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ready"}, enq_ready, 1);
        chk({tag, "_sel"}, sel_out, 0);
        chk({tag, "_approve"}, approve_out, 0);
        chk({tag, "_wash_rst"}, wash_rst, 1);
        chk({tag, "_drop"}, drop, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_washes"}, washes, 0);
    endtask

    initial begin
        logic [1:0] fill [5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        #1 reset_vals("rst");
        repeat (2) @(posedge clk);
        #2 reset = 1;
        @(negedge clk);
        // single detail car through a full wash
        enq_valid = 1; enq_sel = 3; cyc(1);
        chk("a_count1", count, 1);
        enq_valid = 0; cyc(1);
        chk("a_load_count", count, 1);
        chk("a_load_approve", approve_out, 0);
        cyc(1);
        chk("a_sel3", sel_out, 3);
        chk("a_approve", approve_out, 1);
        chk("a_count0", count, 0);
        cyc(2);
        wash_done = 1; cyc(1);
        chk("a_wash_rst", wash_rst, 1);
        chk("a_clr_sel", sel_out, 0);
        chk("a_washes", washes, 1);
        wash_done = 0; cyc(1);
        chk("a_rst_low", wash_rst, 0);
        // two cars: second loads three edges after the completion edge
        enq_valid = 1; enq_sel = 1; cyc(1);
        enq_sel = 2; cyc(1);
        enq_valid = 0; cyc(1);
        chk("b_sel1", sel_out, 1);
        chk("b_count", count, 1);
        cyc(1);
        wash_done = 1; cyc(1);
        chk("b_washes", washes, 2);
        chk("b_wash_rst", wash_rst, 1);
        wash_done = 0; cyc(1);
        chk("b_idle_appr", approve_out, 0);
        cyc(1);
        chk("b_load_appr", approve_out, 0);
        cyc(1);
        chk("b_sel2", sel_out, 2);
        chk("b_appr", approve_out, 1);
        // completion edge in the very cycle the watchdog expires
        cyc(9);
        chk("d_still_wash", approve_out, 1);
        wash_done = 1; cyc(1);
        chk("d_fault_clear", fault, 0);
        chk("d_washes", washes, 3);
        chk("d_wash_rst", wash_rst, 1);
        wash_done = 0; cyc(1);
        // watchdog expiry with wash_done held low
        enq_valid = 1; enq_sel = 3; cyc(1);
        enq_valid = 0; cyc(2);
        chk("c_sel3", sel_out, 3);
        cyc(9);
        chk("c_pre_fault", fault, 0);
        cyc(1);
        chk("c_fault", fault, 1);
        chk("c_wash_rst", wash_rst, 1);
        chk("c_washes", washes, 3);
        cyc(1);
        enq_valid = 1; enq_sel = 1; cyc(1);
        enq_valid = 0; cyc(2);
        wash_done = 1; cyc(1);
        chk("c_washes4", washes, 4);
        chk("c_sticky", fault, 1);
        wash_done = 0; cyc(1);
        // fill the queue behind a running wash
        enq_valid = 1; enq_sel = 3; cyc(1);
        enq_valid = 0; cyc(2);
        for (int i = 0; i < 5; i++) begin
            enq_valid = 1; enq_sel = fill[i]; cyc(1);
            if (i == 3) begin
                chk("e_full", full, 1);
                chk("e_ready", enq_ready, 0);
            end
        end
        enq_valid = 0;
        chk("e_drop", drop, 1);
        chk("e_count4", count, 4);
        cyc(1);
        chk("e_drop_end", drop, 0);
        wash_done = 1; cyc(1);
        chk("e_washes", washes, 5);
        wash_done = 0; cyc(2);
        chk("e_load_full", full, 1);
        enq_valid = 1; enq_sel = 1; cyc(1);
        enq_valid = 0;
        chk("e_deq_reject", count, 3);
        chk("e_head_sel", sel_out, 1);
        chk("e_drop2", drop, 1);
        cyc(1);
        // reset in the middle of a wash with cars waiting
        @(posedge clk);
        #2 reset = 0;
        #1 reset_vals("mid");
        @(posedge clk);
        #2 reset = 1;
        @(negedge clk);
        // selection 0 is rejected and never starts a wash
        enq_valid = 1; enq_sel = 0; cyc(1);
        enq_valid = 0;
        chk("f_drop", drop, 1);
        chk("f_count", count, 0);
        cyc(1);
        chk("f_drop_end", drop, 0);
        cyc(1);
        chk("f_idle_appr", approve_out, 0);
        chk("f_idle_sel", sel_out, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
